// File: rtl/fetch_stage_pkg.sv
// Shared types and helpers for the instruction fetch stage.
//   addr_t / inst_t    : 32-bit address and instruction words
//   fetch_exc_e        : exception tag carried with every fetched entry
//   fetch_entry_t      : {pc, inst, exc} as held in the output queue
//   fetch_state_e      : fetch FSM states
//   ialigned           : 4-byte alignment test
//   x_in_range         : inclusive unsigned window test
package fetch_stage_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] inst_t;

   typedef enum logic [1:0] {
      EXC_NONE         = 2'd0,
      EXC_MISALIGNED   = 2'd1,
      EXC_ACCESS_FAULT = 2'd2
   } fetch_exc_e;

   localparam inst_t INST_NOP = 32'h0000_0013;

   typedef struct packed {
      addr_t      pc;
      inst_t      inst;
      fetch_exc_e exc;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      S_ISSUE = 2'd0,
      S_WAIT  = 2'd1,
      S_HALT  = 2'd2
   } fetch_state_e;

   function automatic logic ialigned(addr_t a);
      return a[1:0] == 2'b00;
   endfunction

   function automatic logic x_in_range(addr_t a, addr_t lo, addr_t hi);
      return (a >= lo) && (a <= hi);
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage, instruction memory and decode.
//   imem_req_*  : request channel (valid/ready), address stable until accepted
//   imem_resp_* : response channel, always accepted, may flag a bus error
//   out_*       : decode channel (valid/ready) carrying {pc, inst, exc}
// master = fetch stage, slave = memory + decode side.
interface fetch_stage_if;
   import fetch_stage_pkg::*;

   logic       imem_req_valid;
   logic       imem_req_ready;
   addr_t      imem_req_addr;
   logic       imem_resp_valid;
   inst_t      imem_resp_inst;
   logic       imem_resp_error;
   logic       out_valid;
   logic       out_ready;
   addr_t      out_pc;
   inst_t      out_inst;
   fetch_exc_e out_exc;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid, imem_resp_inst, imem_resp_error,
      output out_valid, out_pc, out_inst, out_exc,
      input  out_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid, imem_resp_inst, imem_resp_error,
      input  out_valid, out_pc, out_inst, out_exc,
      output out_ready
   );

endinterface

// File: rtl/fetch_stage_queue.sv
// fetch_queue: circular FIFO of fetch entries feeding decode.
//   clk, reset         : clock, async active-high reset
//   flush              : drop all entries (wins over push)
//   push, push_entry   : enqueue; accepted when not full or popping this cycle
//   pop                : head consumed by decode
//   head_valid/entry   : head register, presented with no extra latency
//   free_slots         : QDEPTH - occupancy
module fetch_queue
   import fetch_stage_pkg::*;
#(
   parameter int  QDEPTH = 2,
   localparam int PTR_W  = $clog2(QDEPTH),
   localparam int CNT_W  = PTR_W + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               push,
   input  fetch_entry_t       push_entry,
   input  logic               pop,
   output logic               head_valid,
   output fetch_entry_t       head_entry,
   output logic [CNT_W-1:0]   free_slots
);

   fetch_entry_t       mem_q [QDEPTH];
   fetch_entry_t       mem_d [QDEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               do_push, do_pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CNT_W'(QDEPTH)) || do_pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < QDEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_valid = (count_q != '0);
   assign head_entry = mem_q[rd_ptr_q];
   assign free_slots = CNT_W'(QDEPTH) - count_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, imem request issue and fetch queue.
//   clk, reset                : clock, async active-high reset
//   redirect_valid/pc         : flush and restart fetch at redirect_pc
//   bus (master)              : imem request/response and decode output
//
// state   | meaning
// S_ISSUE | screen pc, request it from imem when queue credit allows
// S_WAIT  | one request outstanding; discard_q marks it as stale
// S_HALT  | fault entry queued, idle until the next redirect
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter addr_t RESET_VECTOR = 32'h8000_0000,
   parameter addr_t IMEM_BASE    = 32'h8000_0000,
   parameter addr_t IMEM_LAST    = 32'h8000_FFFF,
   parameter int    QDEPTH       = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          redirect_valid,
   input  addr_t         redirect_pc,
   fetch_stage_if.master bus
);

   localparam int CNT_W = $clog2(QDEPTH) + 1;

   fetch_state_e     state_q, state_d;
   addr_t            pc_q, pc_d;
   addr_t            req_pc_q, req_pc_d;
   logic             discard_q, discard_d;

   logic             q_push;
   fetch_entry_t     q_push_entry;
   logic             q_pop;
   logic             q_head_valid;
   fetch_entry_t     q_head;
   logic [CNT_W-1:0] q_free;
   logic             has_credit;
   logic             req_valid;

   // An outstanding request already owns one free slot.
   assign has_credit = q_free > CNT_W'(state_q == S_WAIT);
   assign q_pop      = q_head_valid && bus.out_ready;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      discard_d    = discard_q;
      q_push       = 1'b0;
      q_push_entry = '0;
      req_valid    = 1'b0;
      if (redirect_valid) begin
         pc_d = redirect_pc;
         if ((state_q == S_WAIT) && !bus.imem_resp_valid) begin
            discard_d = 1'b1;
         end else begin
            discard_d = 1'b0;
            state_d   = S_ISSUE;
         end
      end else begin
         case (state_q)
            S_ISSUE: begin
               if (!ialigned(pc_q)) begin
                  if (q_free != '0) begin
                     q_push       = 1'b1;
                     q_push_entry = '{pc: pc_q, inst: INST_NOP, exc: EXC_MISALIGNED};
                     state_d      = S_HALT;
                  end
               end else if (!x_in_range(pc_q, IMEM_BASE, IMEM_LAST)) begin
                  if (q_free != '0) begin
                     q_push       = 1'b1;
                     q_push_entry = '{pc: pc_q, inst: INST_NOP, exc: EXC_ACCESS_FAULT};
                     state_d      = S_HALT;
                  end
               end else begin
                  req_valid = has_credit;
                  if (has_credit && bus.imem_req_ready) begin
                     req_pc_d = pc_q;
                     state_d  = S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (bus.imem_resp_valid) begin
                  if (discard_q) begin
                     discard_d = 1'b0;
                     state_d   = S_ISSUE;
                  end else if (bus.imem_resp_error) begin
                     q_push       = 1'b1;
                     q_push_entry = '{pc: req_pc_q, inst: INST_NOP, exc: EXC_ACCESS_FAULT};
                     state_d      = S_HALT;
                  end else begin
                     q_push       = 1'b1;
                     q_push_entry = '{pc: req_pc_q, inst: bus.imem_resp_inst, exc: EXC_NONE};
                     pc_d         = req_pc_q + 32'd4;
                     state_d      = S_ISSUE;
                  end
               end
            end
            S_HALT: begin
            end
            default: begin
               state_d = S_ISSUE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_ISSUE;
         pc_q      <= RESET_VECTOR;
         req_pc_q  <= '0;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         req_pc_q  <= req_pc_d;
         discard_q <= discard_d;
      end
   end

   fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clk        (clk),
      .reset      (reset),
      .flush      (redirect_valid),
      .push       (q_push),
      .push_entry (q_push_entry),
      .pop        (q_pop),
      .head_valid (q_head_valid),
      .head_entry (q_head),
      .free_slots (q_free)
   );

   // Held low while reset is asserted so no request leaks out of reset.
   assign bus.imem_req_valid = req_valid && !reset;
   assign bus.imem_req_addr  = pc_q;
   assign bus.out_valid      = q_head_valid;
   assign bus.out_pc         = q_head.pc;
   assign bus.out_inst       = q_head.inst;
   assign bus.out_exc        = q_head.exc;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam addr_t RV   = 32'h8000_0000;
   localparam addr_t BASE = 32'h8000_0000;
   localparam addr_t LAST = 32'h8000_FFFF;
   localparam int    QD   = 2;

   logic  clk = 1'b0;
   logic  reset;
   logic  redirect_valid;
   addr_t redirect_pc;

   fetch_stage_if bus();

   fetch_stage #(
      .RESET_VECTOR (RV),
      .IMEM_BASE    (BASE),
      .IMEM_LAST    (LAST),
      .QDEPTH       (QD)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   int           checks = 0;
   int           errors = 0;
   fetch_entry_t sb[$];
   int           n_pop = 0;
   int           n_acc = 0;
   addr_t        last_acc_addr = '0;

   int    lat_min = 0, lat_max = 0;
   bit    ready_rand = 0, out_rand = 0, hold_out = 0;
   bit    err_en = 0;
   addr_t err_addr = '0;
   bit    mem_pending = 0;
   int    mem_cnt = 0;
   addr_t mem_addr = '0;

   function automatic inst_t inst_of(addr_t a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Reference: the architectural sequence of entries decode should see
   // after fetch (re)starts at s, ending at the first fault.
   function automatic void restart(addr_t s);
      addr_t a;
      fetch_entry_t e;
      sb.delete();
      n_pop = 0;
      a = s;
      for (int i = 0; i < 256; i++) begin
         e.pc = a;
         if (a % 4 != 0) begin
            e.inst = 32'h0000_0013; e.exc = EXC_MISALIGNED; sb.push_back(e); break;
         end else if (a < BASE || a > LAST || (err_en && a == err_addr)) begin
            e.inst = 32'h0000_0013; e.exc = EXC_ACCESS_FAULT; sb.push_back(e); break;
         end
         e.inst = inst_of(a); e.exc = EXC_NONE; sb.push_back(e);
         a = a + 32'd4;
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor / scoreboard
   initial begin
      fetch_entry_t e;
      forever begin
         @(negedge clk);
         if (!reset && bus.out_valid && bus.out_ready) begin
            n_pop++;
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_entry: got pc %h, expected no entry", bus.out_pc);
            end else begin
               e = sb.pop_front();
               check("out_pc", bus.out_pc, e.pc);
               check("out_inst", bus.out_inst, e.inst);
               check("out_exc", 32'(bus.out_exc), 32'(e.exc));
            end
         end
      end
   end

   // Instruction memory model
   initial begin
      logic  acc_now, resp_now;
      addr_t acc_addr;
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_inst  = '0;
      bus.imem_resp_error = 1'b0;
      forever begin
         @(negedge clk);
         acc_now  = bus.imem_req_valid && bus.imem_req_ready;
         acc_addr = bus.imem_req_addr;
         resp_now = bus.imem_resp_valid;
         @(posedge clk); #1;
         if (reset) begin
            mem_pending = 0;
            bus.imem_resp_valid = 1'b0;
         end else begin
            if (resp_now) mem_pending = 0;
            bus.imem_resp_valid = 1'b0;
            if (acc_now) begin
               n_acc++;
               last_acc_addr = acc_addr;
               check("one_outstanding", 32'(mem_pending), 32'd0);
               check("req_addr_legal",
                     32'(acc_addr[1:0] == 2'b00 && acc_addr >= BASE && acc_addr <= LAST), 32'd1);
               mem_pending = 1;
               mem_addr    = acc_addr;
               mem_cnt     = $urandom_range(lat_max, lat_min);
            end
            if (mem_pending) begin
               if (mem_cnt == 0) begin
                  bus.imem_resp_valid = 1'b1;
                  bus.imem_resp_inst  = inst_of(mem_addr);
                  bus.imem_resp_error = err_en && (mem_addr == err_addr);
               end else begin
                  mem_cnt--;
               end
            end
         end
         bus.imem_req_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Decode-side ready
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus.out_ready = hold_out ? 1'b0 : (out_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_redirect(input addr_t a);
      redirect_valid = 1'b1;
      redirect_pc    = a;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      restart(a);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k = 0;
      while (sb.size() != 0 && k < budget) begin @(posedge clk); #1; k++; end
      check(name, 32'(sb.size()), 32'd0);
   endtask

   task automatic wait_pending(input int budget);
      int k = 0;
      while (!mem_pending && k < budget) begin @(posedge clk); #1; k++; end
      check("mem_pending_seen", 32'(mem_pending), 32'd1);
   endtask

   localparam int NT = 7;
   addr_t targets [NT] = '{32'h8000_0000, 32'h8000_0040, 32'h8000_FFF0, 32'h8000_0102,
                           32'h7FFF_FFF0, 32'h8000_0200, 32'h8001_0000};

   initial begin
      int n_acc0;
      int k;
      addr_t tgt;
      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_pc", bus.out_pc, 32'd0);
      check("rst_out_inst", bus.out_inst, 32'd0);
      check("rst_out_exc", 32'(bus.out_exc), 32'd0);
      reset = 1'b0;
      restart(RV);

      // Sequential fetch, memory always ready, 1-cycle response
      cycles(20);
      check("seq_pops_ge3", 32'(n_pop >= 3), 32'd1);

      // Back-pressure from decode
      hold_out = 1;
      cycles(12);
      @(negedge clk);
      check("hold_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk); #1;
      hold_out = 0; out_rand = 1; ready_rand = 1; lat_max = 3;
      cycles(40);

      // Redirect with a request outstanding
      wait_pending(50);
      do_redirect(32'h8000_0100);
      cycles(30);
      check("redir_progress", 32'(n_pop > 0), 32'd1);

      // Misaligned target
      do_redirect(32'h8000_0102);
      n_acc0 = n_acc;
      wait_drain("misaligned_drain", 60);
      cycles(10);
      check("misaligned_no_req", 32'(n_acc - n_acc0), 32'd0);

      // Below the window, then the top of the window
      do_redirect(32'h7FFF_FFFC);
      n_acc0 = n_acc;
      wait_drain("low_fault_drain", 60);
      cycles(3);
      check("low_fault_no_req", 32'(n_acc - n_acc0), 32'd0);
      do_redirect(32'h8000_FFFC);
      n_acc0 = n_acc;
      @(negedge clk);
      check("redir_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("redir_req_addr", bus.imem_req_addr, 32'h8000_FFFC);
      @(posedge clk); #1;
      wait_drain("top_window_drain", 60);
      cycles(5);
      check("top_window_reqs", 32'(n_acc - n_acc0), 32'd1);

      // Bus error on 8000_0010
      err_en = 1; err_addr = 32'h8000_0010;
      do_redirect(32'h8000_0000);
      n_acc0 = n_acc;
      wait_drain("bus_err_drain", 150);
      cycles(5);
      check("bus_err_reqs", 32'(n_acc - n_acc0), 32'd5);

      // Reset while waiting on a slow response
      err_en = 0; ready_rand = 0; lat_min = 6; lat_max = 6;
      do_redirect(32'h8000_0020);
      wait_pending(20);
      cycles(2);
      #2 reset = 1'b1;
      @(negedge clk);
      check("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_out_pc", bus.out_pc, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      restart(RV);
      lat_min = 0; lat_max = 3;
      n_acc0 = n_acc;
      k = 0;
      while (n_acc == n_acc0 && k < 20) begin @(posedge clk); #1; k++; end
      check("post_rst_first_req", last_acc_addr, RV);
      cycles(20);

      // Random soak with redirects and error injection
      ready_rand = 1; out_rand = 1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            tgt      = targets[$urandom_range(0, NT - 1)];
            err_en   = ($urandom_range(0, 1) == 1);
            err_addr = tgt + 32'd12;
            do_redirect(tgt);
         end else begin
            cycles(1);
         end
      end
      out_rand = 0;
      cycles(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
